mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter PRIO_DATA, default 1: 1 = fixed data-over-instruction priority; 0 = round-robin, last-served port loses ties.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst_req  input  1  instruction requester request; held until inst_addr_ok.
REQ-005 inst_wr, inst_wstrb, inst_addr, inst_wdata  input  1/4/32/32  instruction request write flag, byte strobes, address, write data.
REQ-006 inst_addr_ok  output  1  instruction request accepted this cycle.
REQ-007 inst_data_ok  output  1  instruction transaction completes this cycle.
REQ-008 inst_rdata  output  32  read data, valid with inst_data_ok.
REQ-009 data_req, data_wr, data_wstrb, data_addr, data_wdata  input  1/1/4/32/32  data requester (load/store path), same meaning as instruction port.
REQ-010 data_addr_ok, data_data_ok  output  1/1  data port accept / complete.
REQ-011 data_rdata  output  32  read data, valid with data_data_ok.
REQ-012 bus_req  output  1  shared SRAM-like bus request.
REQ-013 bus_wr, bus_wstrb, bus_addr, bus_wdata  output  1/4/32/32  latched fields of granted request.
REQ-014 bus_addr_ok  input  1  bus accepted address phase.
REQ-015 bus_data_ok  input  1  bus completed data phase.
REQ-016 bus_rdata  input  32  bus read data, valid with bus_data_ok.

Function
REQ-017 FSM states IDLE, ADDR, DATA; at most one outstanding bus transaction.
REQ-018 IDLE: if any request present, grant one port, assert that port's addr_ok combinationally in the same cycle, latch wr/wstrb/addr/wdata and grant id, go ADDR; no request -> stay IDLE.
REQ-019 Arbitration, PRIO_DATA=1: data_req wins whenever both requests present; PRIO_DATA=0: both present -> port not served by the last completed transaction wins; after reset the data port wins first.
REQ-020 Only the granted port sees addr_ok; the losing port receives no addr_ok and keeps its request pending.
REQ-021 ADDR: bus_req=1 with latched fields; bus_addr_ok=1 -> go DATA next cycle; else stay ADDR with fields unchanged.
REQ-022 DATA: bus_req=0; bus_data_ok=1 -> granted port's data_ok=1 same cycle, its rdata=bus_rdata, go IDLE; round-robin last-served updates on this edge.
REQ-023 Minimum latency: request accepted cycle N, bus_req cycle N+1, data_ok cycle N+2 when bus responds immediately; no new accept in the completion cycle (next accept earliest N+3).
REQ-024 bus_addr_ok outside ADDR and bus_data_ok outside DATA are ignored and produce no requester response.
REQ-025 Write transactions complete identically to reads; rdata content on write completion is don't-care.
REQ-026 inst_rdata and data_rdata drive bus_rdata directly; meaningful only while respective data_ok=1.
REQ-027 Requester fields changing after addr_ok do not affect the bus transaction.
REQ-028 All *_addr_ok and *_data_ok are single-cycle pulses per transaction; never both ports' data_ok in one cycle.

Reset
REQ-029 reset=1 asynchronously forces IDLE, clears grant and latched fields to 0, round-robin pointer to "instruction last served"; bus_req, all addr_ok/data_ok = 0 during and after reset until a new accept.
REQ-030 Reset mid-transaction abandons it: no data_ok issued for the aborted transaction; bus responses arriving after reset are ignored per REQ-024.

Verification
REQ-031 Single data read: data_req=1, addr=0x0000_1000, bus_addr_ok and bus_data_ok immediate, bus_rdata=0xDEAD_BEEF -> data_addr_ok cycle 0, bus_req cycle 1 with bus_addr=0x1000, data_data_ok cycle 2 with data_rdata=0xDEAD_BEEF.
REQ-032 Simultaneous requests, PRIO_DATA=1: inst_req and data_req held high -> data served first, inst_addr_ok at cycle 3, inst_data_ok at cycle 5.
REQ-033 Round-robin, PRIO_DATA=0, both requests held for 4 transactions -> grant order data, inst, data, inst.
REQ-034 Bus stall: bus_addr_ok low 3 cycles, bus_data_ok low 2 cycles, store wstrb=0xF wdata=0x1234_5678 -> bus fields stable throughout, bus_req high exactly 4 cycles, data_data_ok one pulse.
REQ-035 Reset in DATA state: assert reset before bus_data_ok -> no data_ok pulse, bus_req=0, state IDLE; subsequent inst read completes normally.
REQ-036 Spurious responses: bus_data_ok=1 and bus_addr_ok=1 in IDLE -> no addr_ok/data_ok on either port, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates an instruction and a data requester onto one
// SRAM-like bus with at most one outstanding transaction.
module mem_bus_arbiter #(
  parameter bit PRIO_DATA = 1'b1,
  localparam int unsigned ADDR_W = 32,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state;
  logic   grant_data;   // 1: current transaction belongs to the data port
  logic   last_data;    // 1: last completed transaction served the data port
  req_t   lat;

  logic   sel_data_c;
  logic   accept_c;
  logic   complete_c;
  req_t   inst_fields_c;
  req_t   data_fields_c;

  assign inst_fields_c = '{wr: inst_wr, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
  assign data_fields_c = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

  // Data wins alone, under fixed priority, or when instruction was served last.
  assign sel_data_c = data_req & (~inst_req | PRIO_DATA | ~last_data);
  assign accept_c   = ~reset & (state == IDLE) & (inst_req | data_req);
  assign complete_c = ~reset & (state == DATA) & bus_data_ok;

  assign inst_addr_ok = accept_c & ~sel_data_c;
  assign data_addr_ok = accept_c & sel_data_c;
  assign inst_data_ok = complete_c & ~grant_data;
  assign data_data_ok = complete_c & grant_data;
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

  assign bus_req   = (state == ADDR);
  assign bus_wr    = lat.wr;
  assign bus_wstrb = lat.wstrb;
  assign bus_addr  = lat.addr;
  assign bus_wdata = lat.wdata;

  // Transaction FSM: grant and latch in IDLE, address phase, data phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_data <= 1'b0;
      last_data  <= 1'b0;
      lat        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            grant_data <= sel_data_c;
            lat        <= sel_data_c ? data_fields_c : inst_fields_c;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) state <= DATA;
        end
        DATA: begin
          if (bus_data_ok) begin
            last_data <= grant_data;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: round-robin (index 0) and fixed-priority (index 1)
// arbiters share stimulus; a transaction-level model checks both every cycle.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  logic [1:0]  inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, bus_wr;
  logic [31:0] inst_rdata [2];
  logic [31:0] data_rdata [2];
  logic [31:0] bus_addr [2];
  logic [31:0] bus_wdata [2];
  logic [3:0]  bus_wstrb [2];

  mem_bus_arbiter #(.PRIO_DATA(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
    .bus_req(bus_req[0]), .bus_wr(bus_wr[0]), .bus_wstrb(bus_wstrb[0]),
    .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.PRIO_DATA(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
    .bus_req(bus_req[1]), .bus_wr(bus_wr[1]), .bus_wstrb(bus_wstrb[1]),
    .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: one pending transaction record per arbiter.
  string       tag [2] = '{"rr", "fp"};
  bit          m_busy [2];
  bit          m_addr_done [2];
  bit          m_port [2];   // 1 = data port owns the pending transaction
  bit          m_last [2];   // 1 = data port served by last completion
  logic        m_wr [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  bit          e_sel, e_acc, e_done, e_breq;

  // Compare both arbiters against the model each cycle, then advance the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        chk({tag[d], " reset handshakes"},
            32'({inst_addr_ok[d], inst_data_ok[d], data_addr_ok[d], data_data_ok[d], bus_req[d]}), 32'd0);
        chk({tag[d], " reset bus_addr"}, bus_addr[d], 32'd0);
        chk({tag[d], " reset bus_wdata"}, bus_wdata[d], 32'd0);
        chk({tag[d], " reset bus_wr/wstrb"}, 32'({bus_wr[d], bus_wstrb[d]}), 32'd0);
        m_busy[d] = 1'b0; m_addr_done[d] = 1'b0; m_port[d] = 1'b0; m_last[d] = 1'b0;
        m_wr[d] = 1'b0; m_wstrb[d] = 4'd0; m_addr[d] = 32'd0; m_wdata[d] = 32'd0;
      end else begin
        e_sel  = data_req && (!inst_req || d == 1 || !m_last[d]);
        e_acc  = !m_busy[d] && (inst_req || data_req);
        e_done = m_busy[d] && m_addr_done[d] && bus_data_ok;
        e_breq = m_busy[d] && !m_addr_done[d];
        chk({tag[d], " inst_addr_ok"}, 32'(inst_addr_ok[d]), 32'(e_acc && !e_sel));
        chk({tag[d], " data_addr_ok"}, 32'(data_addr_ok[d]), 32'(e_acc && e_sel));
        chk({tag[d], " inst_data_ok"}, 32'(inst_data_ok[d]), 32'(e_done && !m_port[d]));
        chk({tag[d], " data_data_ok"}, 32'(data_data_ok[d]), 32'(e_done && m_port[d]));
        chk({tag[d], " bus_req"}, 32'(bus_req[d]), 32'(e_breq));
        if (e_breq) begin
          chk({tag[d], " bus_addr"}, bus_addr[d], m_addr[d]);
          chk({tag[d], " bus_wdata"}, bus_wdata[d], m_wdata[d]);
          chk({tag[d], " bus_wr/wstrb"}, 32'({bus_wr[d], bus_wstrb[d]}), 32'({m_wr[d], m_wstrb[d]}));
        end
        if (e_done && !m_port[d]) chk({tag[d], " inst_rdata"}, inst_rdata[d], bus_rdata);
        if (e_done && m_port[d])  chk({tag[d], " data_rdata"}, data_rdata[d], bus_rdata);
        if (e_acc) begin
          m_busy[d] = 1'b1; m_addr_done[d] = 1'b0; m_port[d] = e_sel;
          m_wr[d]    = e_sel ? data_wr    : inst_wr;
          m_wstrb[d] = e_sel ? data_wstrb : inst_wstrb;
          m_addr[d]  = e_sel ? data_addr  : inst_addr;
          m_wdata[d] = e_sel ? data_wdata : inst_wdata;
        end else if (e_breq) begin
          if (bus_addr_ok) m_addr_done[d] = 1'b1;
        end else if (e_done) begin
          m_busy[d] = 1'b0;
          m_last[d] = m_port[d];
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1;
    quiet();
    tick();
    reset = 1'b0;
  endtask

  int ia, idn, nreq, npulse, pulse_c, badf;
  bit dflag, iflag;
  int grants[$];
  int exp_order [4] = '{1, 0, 1, 0};

  initial begin
    reset = 1'b1;
    quiet();
    inst_wr = 1'b0; data_wr = 1'b0; inst_wstrb = 4'd0; data_wstrb = 4'd0;
    inst_addr = 32'd0; data_addr = 32'd0; inst_wdata = 32'd0; data_wdata = 32'd0;
    bus_rdata = 32'd0;

    // Requests held during reset must not be accepted.
    inst_req = 1'b1; data_req = 1'b1;
    @(negedge clk);
    chk("reset addr_ok suppressed", 32'({inst_addr_ok[1], data_addr_ok[1]}), 32'd0);
    chk("reset bus_req", 32'(bus_req[1]), 32'd0);
    quiet();
    tick();
    reset = 1'b0;

    // Single data read, immediate bus.
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("read data_addr_ok c0", 32'(data_addr_ok[1]), 32'd1);
    tick(); data_req = 1'b0;
    @(negedge clk);
    chk("read bus_req c1", 32'(bus_req[1]), 32'd1);
    chk("read bus_addr c1", bus_addr[1], 32'h0000_1000);
    tick();
    @(negedge clk);
    chk("read data_data_ok c2", 32'(data_data_ok[1]), 32'd1);
    chk("read data_rdata c2", data_rdata[1], 32'hDEAD_BEEF);
    tick(); quiet();

    // Simultaneous requests under fixed priority.
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h2000; data_addr = 32'h3000;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    ia = -1; idn = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      dflag = data_addr_ok[1];
      iflag = inst_addr_ok[1];
      if (iflag && ia < 0) ia = c;
      if (inst_data_ok[1] && idn < 0) idn = c;
      tick();
      if (dflag) data_req = 1'b0;
      if (iflag) inst_req = 1'b0;
    end
    chk("prio inst_addr_ok cycle", 32'(ia), 32'd3);
    chk("prio inst_data_ok cycle", 32'(idn), 32'd5);
    quiet();

    // Round-robin with both requests held for four transactions.
    do_reset();
    inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    grants.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (inst_addr_ok[0]) grants.push_back(0);
      if (data_addr_ok[0]) grants.push_back(1);
      tick();
    end
    quiet();
    chk("rr grant count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr grant %0d", i), 32'(grants[i]), 32'(exp_order[i]));

    // Stalled store: fields stable, bus_req exactly four cycles.
    do_reset();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_wdata = 32'h1234_5678;
    data_addr = 32'h0000_4000;
    nreq = 0; npulse = 0; pulse_c = -1; badf = 0;
    for (int c = 0; c < 12; c++) begin
      bus_addr_ok = (c == 4);
      bus_data_ok = (c == 7);
      @(negedge clk);
      if (bus_req[1]) begin
        nreq++;
        if (bus_addr[1] !== 32'h4000 || bus_wdata[1] !== 32'h1234_5678 ||
            bus_wstrb[1] !== 4'hF || bus_wr[1] !== 1'b1) badf++;
      end
      if (data_data_ok[1]) begin npulse++; pulse_c = c; end
      dflag = data_addr_ok[1];
      tick();
      if (dflag) begin
        data_req = 1'b0; data_wdata = 32'hFFFF_0000; data_addr = 32'h0; data_wstrb = 4'h0;
      end
    end
    chk("stall bus_req cycles", 32'(nreq), 32'd4);
    chk("stall field changes", 32'(badf), 32'd0);
    chk("stall data_ok pulses", 32'(npulse), 32'd1);
    chk("stall data_ok cycle", 32'(pulse_c), 32'd7);
    quiet(); data_wr = 1'b0;

    // Reset while in the data phase, then a clean instruction read.
    do_reset();
    data_req = 1'b1; data_addr = 32'h5000; bus_addr_ok = 1'b1;
    tick(); data_req = 1'b0;
    tick(); bus_addr_ok = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort bus_req", 32'(bus_req[1]), 32'd0);
    chk("abort data_data_ok", 32'(data_data_ok[1]), 32'd0);
    tick(); reset = 1'b0; bus_data_ok = 1'b1;
    @(negedge clk);
    chk("abort late data_ok", 32'({inst_data_ok[1], data_data_ok[1]}), 32'd0);
    tick(); bus_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h6000; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    chk("after abort inst_addr_ok", 32'(inst_addr_ok[1]), 32'd1);
    tick(); inst_req = 1'b0;
    @(negedge clk);
    chk("after abort bus_addr", bus_addr[1], 32'h6000);
    tick();
    @(negedge clk);
    chk("after abort inst_data_ok", 32'(inst_data_ok[1]), 32'd1);
    chk("after abort inst_rdata", inst_rdata[1], 32'hCAFE_F00D);
    tick(); quiet();

    // Spurious bus responses while idle.
    do_reset();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("spurious idle %0d", c),
          32'({inst_addr_ok[1], inst_data_ok[1], data_addr_ok[1], data_data_ok[1], bus_req[1]}), 32'd0);
      tick();
    end
    data_req = 1'b1; data_addr = 32'h7000;
    @(negedge clk);
    chk("spurious still idle", 32'(data_addr_ok[1]), 32'd1);
    tick(); data_req = 1'b0;
    repeat (3) tick();
    quiet();

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      reset       = ($urandom_range(0, 199) == 0);
      inst_req    = 1'($urandom_range(0, 1));
      data_req    = 1'($urandom_range(0, 1));
      inst_wr     = 1'($urandom_range(0, 1));
      data_wr     = 1'($urandom_range(0, 1));
      inst_wstrb  = 4'($urandom);
      data_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      data_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wdata  = $urandom;
      bus_addr_ok = ($urandom_range(0, 2) != 0);
      bus_data_ok = ($urandom_range(0, 2) != 0);
      bus_rdata   = $urandom;
    end
    tick();
    reset = 1'b0;
    quiet();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
